axis_frame_sanitizer: RTL and testbench



---
 rtl/axis_frame_sanitizer_pkg.sv | 17 +
 rtl/axis_frame_sanitizer_reg_slice.sv | 46 ++++
 rtl/axis_frame_sanitizer.sv | 201 ++++++++++++++++++++
 tb/tb_axis_frame_sanitizer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_sanitizer_pkg.sv
// Shared types and constants for the AXI4-Stream frame sanitizer.
package axis_frame_sanitizer_pkg;

   localparam int unsigned STAT_W = 16;

   // RGB565 black, the default fill for padded pixels
   localparam logic [15:0] PAD_RGB565_BLACK = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PASS,
      ST_PAD_LINE,
      ST_DROP_LINE,
      ST_PAD_FRAME
   } sanitizer_state_e;

endpackage

// File: rtl/axis_frame_sanitizer_reg_slice.sv
// Single-stage AXI4-Stream output register; stable while the sink stalls.
module axis_reg_slice #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned USER_WIDTH = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   input  logic [USER_WIDTH-1:0] i_user,
   output logic                  o_load_en_c,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic [USER_WIDTH-1:0] o_user,
   input  logic                  i_ready
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_last;
   logic [USER_WIDTH-1:0] r_user;

   assign o_load_en_c = !r_valid || i_ready;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_user  <= '0;
      end else if (o_load_en_c) begin
         r_valid <= i_valid;
         r_data  <= i_data;
         r_last  <= i_last;
         r_user  <= i_user;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_user  = r_user;

endmodule

// File: rtl/axis_frame_sanitizer.sv
// Forces every output frame to exactly H_RES x V_RES beats (pad/truncate/realign).
// Optional frame/error counters built only with AXIS_FRAME_SANITIZER_STATS_EN.
module axis_frame_sanitizer
   import axis_frame_sanitizer_pkg::*;
#(
   parameter int unsigned          H_RES      = 800,
   parameter int unsigned          V_RES      = 600,
   parameter int unsigned          DATA_WIDTH = 16,
   parameter int unsigned          USER_WIDTH = 1,
   parameter logic [DATA_WIDTH-1:0] PAD_COLOR = DATA_WIDTH'(PAD_RGB565_BLACK)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
   input  logic                  s_axis_tvalid_i,
   output logic                  s_axis_tready_o,
   input  logic                  s_axis_tlast_i,
   input  logic [USER_WIDTH-1:0] s_axis_tuser_i,
   output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
   output logic                  m_axis_tvalid_o,
   input  logic                  m_axis_tready_i,
   output logic                  m_axis_tlast_o,
   output logic [USER_WIDTH-1:0] m_axis_tuser_o,
   output logic                  sof_err_o,
   output logic                  short_err_o,
   output logic                  long_err_o,
   output logic [15:0]           frame_cnt_o,
   output logic [15:0]           err_cnt_o
);

   localparam int unsigned XW = $clog2(H_RES);
   localparam int unsigned YW = $clog2(V_RES);

   sanitizer_state_e      r_state, w_state_nxt;
   logic [XW-1:0]         r_x;
   logic [YW-1:0]         r_y;
   logic                  w_load_en;
   logic                  w_emit;
   logic [DATA_WIDTH-1:0] w_emit_data;
   logic                  w_tready;
   logic                  w_sof_ev, w_short_ev, w_long_ev;
   logic                  w_x_last, w_y_last, w_origin, w_sof;
   logic                  r_sof_err, r_short_err, r_long_err;

   assign w_x_last = (r_x == XW'(H_RES - 1));
   assign w_y_last = (r_y == YW'(V_RES - 1));
   assign w_origin = (r_x == '0) && (r_y == '0);
   assign w_sof    = s_axis_tuser_i[0];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state, emit/consume decisions and error events; emits only when load_en
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_emit_data = '0;
      w_tready    = 1'b0;
      w_sof_ev    = 1'b0;
      w_short_ev  = 1'b0;
      w_long_ev   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tready = w_load_en;
            if (s_axis_tvalid_i && w_load_en && w_sof) begin
               w_emit      = 1'b1;
               w_emit_data = s_axis_tdata_i;
               w_state_nxt = ST_PASS;
            end
         end
         ST_PASS: begin
            if (s_axis_tvalid_i && w_sof && !w_origin) begin
               w_sof_ev    = 1'b1;
               w_state_nxt = ST_PAD_FRAME;
            end else begin
               w_tready = w_load_en;
               if (s_axis_tvalid_i && w_load_en) begin
                  w_emit      = 1'b1;
                  w_emit_data = s_axis_tdata_i;
                  if (s_axis_tlast_i && !w_x_last) begin
                     w_short_ev  = 1'b1;
                     w_state_nxt = ST_PAD_LINE;
                  end else if (w_x_last && !s_axis_tlast_i) begin
                     w_long_ev   = 1'b1;
                     w_state_nxt = ST_DROP_LINE;
                  end else if (w_x_last && w_y_last) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
         end
         ST_PAD_LINE: begin
            if (w_load_en) begin
               w_emit      = 1'b1;
               w_emit_data = PAD_COLOR;
               if (w_x_last) w_state_nxt = w_y_last ? ST_IDLE : ST_PASS;
            end
         end
         ST_DROP_LINE: begin
            // y has already advanced here, so y==0 means the frame is complete
            if (s_axis_tvalid_i && w_sof) begin
               w_sof_ev    = (r_y != '0);
               w_state_nxt = (r_y == '0) ? ST_IDLE : ST_PAD_FRAME;
            end else begin
               w_tready = 1'b1;
               if (s_axis_tvalid_i && s_axis_tlast_i)
                  w_state_nxt = (r_y == '0) ? ST_IDLE : ST_PASS;
            end
         end
         ST_PAD_FRAME: begin
            if (w_load_en) begin
               w_emit      = 1'b1;
               w_emit_data = PAD_COLOR;
               if (w_x_last && w_y_last) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign s_axis_tready_o = w_tready;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_emit) begin
         if (w_x_last) begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + YW'(1);
         end else begin
            r_x <= r_x + XW'(1);
         end
      end
   end

   axis_reg_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .USER_WIDTH (USER_WIDTH)
   ) u_out_slice (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_valid     (w_emit),
      .i_data      (w_emit_data),
      .i_last      (w_x_last),
      .i_user      (USER_WIDTH'(w_origin)),
      .o_load_en_c (w_load_en),
      .o_valid     (m_axis_tvalid_o),
      .o_data      (m_axis_tdata_o),
      .o_last      (m_axis_tlast_o),
      .o_user      (m_axis_tuser_o),
      .i_ready     (m_axis_tready_i)
   );

   // Sticky flags: a same-cycle error wins over clear
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sof_err   <= 1'b0;
         r_short_err <= 1'b0;
         r_long_err  <= 1'b0;
      end else begin
         r_sof_err   <= (r_sof_err   && !clr_i) || w_sof_ev;
         r_short_err <= (r_short_err && !clr_i) || w_short_ev;
         r_long_err  <= (r_long_err  && !clr_i) || w_long_ev;
      end
   end

   assign sof_err_o   = r_sof_err;
   assign short_err_o = r_short_err;
   assign long_err_o  = r_long_err;

`ifdef AXIS_FRAME_SANITIZER_STATS_EN
   logic              w_any_ev, w_frame_done;
   logic [STAT_W-1:0] r_frame_cnt, r_err_cnt;

   assign w_any_ev     = w_sof_ev || w_short_ev || w_long_ev;
   assign w_frame_done = w_emit && w_x_last && w_y_last;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (clr_i)             r_frame_cnt <= STAT_W'(w_frame_done);
         else if (w_frame_done) r_frame_cnt <= r_frame_cnt + STAT_W'(1);
         if (clr_i)                             r_err_cnt <= STAT_W'(w_any_ev);
         else if (w_any_ev && r_err_cnt != '1)  r_err_cnt <= r_err_cnt + STAT_W'(1);
      end
   end

   assign frame_cnt_o = r_frame_cnt;
   assign err_cnt_o   = r_err_cnt;
`else
   assign frame_cnt_o = '0;
   assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_axis_frame_sanitizer.sv
// Directed bench for axis_frame_sanitizer at 8x4 with red padding.
module tb_axis_frame_sanitizer;

   localparam int H = 8;
   localparam int V = 4;
   localparam logic [15:0] PAD = 16'hF800;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
      logic        u;
   } beat_t;

   logic        clk, rst_n, clr_i;
   logic [15:0] s_data;
   logic        s_valid, s_ready, s_last;
   logic [0:0]  s_user;
   logic [15:0] m_data;
   logic        m_valid, m_ready, m_last;
   logic [0:0]  m_user;
   logic        sof_err, short_err, long_err;
   logic [15:0] frame_cnt, err_cnt;

   axis_frame_sanitizer #(
      .H_RES(H), .V_RES(V), .DATA_WIDTH(16), .USER_WIDTH(1), .PAD_COLOR(PAD)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_i),
      .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready),
      .s_axis_tlast_i(s_last), .s_axis_tuser_i(s_user),
      .m_axis_tdata_o(m_data), .m_axis_tvalid_o(m_valid), .m_axis_tready_i(m_ready),
      .m_axis_tlast_o(m_last), .m_axis_tuser_o(m_user),
      .sof_err_o(sof_err), .short_err_o(short_err), .long_err_o(long_err),
      .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_assert = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    acc_cyc  = 0;
   int    stall_errs = 0;
   bit    rand_ready = 0;
   beat_t exp_q[$];
   beat_t got_q[$];
   int    got_cyc[$];
   bit    prev_stall = 0;
   beat_t prev_beat;

   // Output monitor: captures handshakes and checks stability while stalled
   always @(posedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         got_q.push_back('{m_data, m_last, m_user[0]});
         got_cyc.push_back(cyc);
      end
      if (prev_stall && rst_n && (!m_valid || beat_t'({m_data, m_last, m_user[0]}) != prev_beat))
         stall_errs++;
      prev_stall = rst_n && m_valid && !m_ready;
      prev_beat  = '{m_data, m_last, m_user[0]};
      cyc++;
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      end
   end

   function automatic int e(int v);
`ifdef AXIS_FRAME_SANITIZER_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   function automatic logic [15:0] pix(int f, int y, int x);
      return 16'((f << 8) | (y << 4) | x);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic l, input logic u, input logic clr);
      bit done;
      done = 0;
      @(negedge clk);
      s_data = d; s_last = l; s_user = u; s_valid = 1'b1; clr_i = clr;
      for (int k = 0; k < 300 && !done; k++) begin
         if (k > 0) begin
            @(negedge clk);
            clr_i = 1'b0;
         end
         #1;
         done = s_ready;
         if (done) acc_cyc = cyc;
         @(posedge clk);
      end
      if (!done) chk("send_timeout", 32'(done), 32'd1);
   endtask

   task automatic send_line(input int f, input int y, input int n, input bit with_last);
      for (int x = 0; x < n; x++)
         send(pix(f, y, x), with_last && (x == n - 1), (x == 0) && (y == 0), 1'b0);
   endtask

   task automatic send_frame(input int f);
      for (int y = 0; y < V; y++) send_line(f, y, H, 1'b1);
   endtask

   task automatic push_px(input logic [15:0] d, input int x, input int y);
      exp_q.push_back('{d, (x == H - 1), (x == 0) && (y == 0)});
   endtask

   task automatic push_line(input int f, input int y, input int x0, input int n);
      for (int x = x0; x < x0 + n; x++) push_px(pix(f, y, x), x, y);
   endtask

   task automatic push_pad(input int x0, input int y0, input int n);
      int x, y;
      x = x0; y = y0;
      for (int i = 0; i < n; i++) begin
         push_px(PAD, x, y);
         if (x == H - 1) begin x = 0; y = y + 1; end
         else x = x + 1;
      end
   endtask

   task automatic push_frame(input int f);
      for (int y = 0; y < V; y++) push_line(f, y, 0, H);
   endtask

   task automatic wait_out();
      @(negedge clk);
      s_valid = 1'b0;
      for (int k = 0; k < 2000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic compare(input string tag);
      bit bad;
      bad = 0;
      chk({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size() && !bad; i++) begin
         n_assert++;
         assert (got_q[i] === exp_q[i]) else begin
            n_fail++;
            bad = 1;
            $error("FAIL %s beat %0d: observed d=%h l=%b u=%b expected d=%h l=%b u=%b",
                   tag, i, got_q[i].d, got_q[i].l, got_q[i].u,
                   exp_q[i].d, exp_q[i].l, exp_q[i].u);
         end
      end
   endtask

   task automatic flush();
      got_q.delete();
      exp_q.delete();
      got_cyc.delete();
   endtask

   initial begin
      int a0;
      rst_n = 1'b0; clr_i = 1'b0; m_ready = 1'b1;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_user = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_last_user", 32'({m_last, m_user}), 0);
      chk("rst_flags", 32'({sof_err, short_err, long_err}), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", 32'(s_ready), 1);

      // Two clean frames, 1-cycle latency
      send(pix(0, 0, 0), 1'b0, 1'b1, 1'b0);
      a0 = acc_cyc;
      for (int x = 1; x < H; x++) send(pix(0, 0, x), x == H - 1, 1'b0, 1'b0);
      for (int y = 1; y < V; y++) send_line(0, y, H, 1'b1);
      send_frame(1);
      push_frame(0); push_frame(1);
      wait_out();
      compare("clean");
      if (got_cyc.size() > 0) chk("latency", 32'(got_cyc[0] - a0), 1);
      chk("clean_frame_cnt", 32'(frame_cnt), 32'(e(2)));
      chk("clean_flags", 32'({sof_err, short_err, long_err}), 0);
      chk("clean_err_cnt", 32'(err_cnt), 0);
      flush();

      // Short line 1 (5 pixels) padded to 8
      send_line(2, 0, H, 1'b1);
      send_line(2, 1, 5, 1'b1);
      send_line(2, 2, H, 1'b1);
      send_line(2, 3, H, 1'b1);
      push_line(2, 0, 0, H); push_line(2, 1, 0, 5); push_pad(5, 1, 3);
      push_line(2, 2, 0, H); push_line(2, 3, 0, H);
      wait_out();
      compare("short");
      chk("short_flags", 32'({sof_err, short_err, long_err}), 32'b010);
      chk("short_err_cnt", 32'(err_cnt), 32'(e(1)));
      chk("short_frame_cnt", 32'(frame_cnt), 32'(e(3)));
      flush();

      // Long line 2 (11 pixels) truncated to 8
      send_line(3, 0, H, 1'b1);
      send_line(3, 1, H, 1'b1);
      send_line(3, 2, 11, 1'b1);
      send_line(3, 3, H, 1'b1);
      push_line(3, 0, 0, H); push_line(3, 1, 0, H);
      push_line(3, 2, 0, H); push_line(3, 3, 0, H);
      wait_out();
      compare("long");
      chk("long_flag", 32'(long_err), 1);
      chk("long_err_cnt", 32'(err_cnt), 32'(e(2)));
      chk("long_frame_cnt", 32'(frame_cnt), 32'(e(4)));
      flush();

      // Premature SOF at (3,2): 13 pad beats then new frame
      send_line(4, 0, H, 1'b1);
      send_line(4, 1, H, 1'b1);
      send_line(4, 2, 3, 1'b0);
      send_frame(5);
      push_line(4, 0, 0, H); push_line(4, 1, 0, H); push_line(4, 2, 0, 3);
      push_pad(3, 2, 13);
      push_frame(5);
      wait_out();
      compare("sof");
      chk("sof_flag", 32'(sof_err), 1);
      chk("sof_err_cnt", 32'(err_cnt), 32'(e(3)));
      chk("sof_frame_cnt", 32'(frame_cnt), 32'(e(6)));
      flush();

      // Random backpressure with leading junk
      rand_ready = 1;
      for (int i = 0; i < 3; i++) send(16'hBAD0 + 16'(i), 1'b0, 1'b0, 1'b0);
      send_frame(6);
      push_frame(6);
      wait_out();
      rand_ready = 0;
      @(negedge clk);
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      compare("bp");
      chk("bp_stall_stable", 32'(stall_errs), 0);
      chk("bp_frame_cnt", 32'(frame_cnt), 32'(e(7)));
      flush();

      // Reset mid-frame at (4,1) with a stalled beat in the output register
      send_line(7, 0, H, 1'b1);
      send_line(7, 1, 3, 1'b0);
      push_line(7, 0, 0, H); push_line(7, 1, 0, 3);
      wait_out();
      compare("pre_rst");
      flush();
      @(negedge clk);
      m_ready = 1'b0;
      send(pix(7, 1, 3), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      chk("stalled_valid", 32'(m_valid), 1);
      @(negedge clk);
      rst_n = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      chk("midrst_valid", 32'(m_valid), 0);
      chk("midrst_data", 32'(m_data), 0);
      chk("midrst_cnts", 32'({frame_cnt, err_cnt}), 0);
      chk("midrst_flags", 32'({sof_err, short_err, long_err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h0BAD, 1'b0, 1'b0, 1'b0);
      send_frame(8);
      push_frame(8);
      wait_out();
      compare("post_rst");
      chk("post_rst_frame_cnt", 32'(frame_cnt), 32'(e(1)));
      flush();

      // Short-line error, then clr in the same cycle as a mid-frame SOF
      send_line(9, 0, H, 1'b1);
      send_line(9, 1, 3, 1'b1);
      send_line(9, 2, 2, 1'b0);
      wait_out();
      chk("pre_clr_short", 32'(short_err), 1);
      chk("pre_clr_err_cnt", 32'(err_cnt), 32'(e(1)));
      send(pix(10, 0, 0), 1'b0, 1'b1, 1'b1);
      for (int x = 1; x < H; x++) send(pix(10, 0, x), x == H - 1, 1'b0, 1'b0);
      for (int y = 1; y < V; y++) send_line(10, y, H, 1'b1);
      push_line(9, 0, 0, H); push_line(9, 1, 0, 3); push_pad(3, 1, 5);
      push_line(9, 2, 0, 2); push_pad(2, 2, 14);
      push_frame(10);
      wait_out();
      compare("clr");
      chk("clr_flags", 32'({sof_err, short_err, long_err}), 32'b100);
      chk("clr_err_cnt", 32'(err_cnt), 32'(e(1)));
      chk("clr_frame_cnt", 32'(frame_cnt), 32'(e(2)));
      flush();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
